// File: rtl/alu_control_seq.sv
// alu_control_seq: registered RV32I/M ALU-control decoder with valid/ready handshake and MDU latency sequencing
module alu_control_seq #(
  parameter int M_EXT = 1,
  parameter int MUL_CYCLES = 2,
  parameter int DIV_CYCLES = 32
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [1:0] in_alu_op,
  input  logic [2:0] in_funct3,
  input  logic [6:0] in_funct7,
  input  logic       flush,
  input  logic       ex_ready,
  output logic       out_valid,
  output logic [4:0] out_alu_op,
  output logic       out_illegal,
  output logic       out_mdu_start,
  output logic       out_mdu_kill
);
  localparam int MAX_LAT = MUL_CYCLES > DIV_CYCLES ? MUL_CYCLES : DIV_CYCLES;
  localparam int CW = $clog2(MAX_LAT + 1);
  localparam logic [CW-1:0] MUL_L = CW'(MUL_CYCLES - 1);
  localparam logic [CW-1:0] DIV_L = CW'(DIV_CYCLES - 1);
  localparam logic [4:0] OP_AND = 5'b00000, OP_OR = 5'b00001, OP_ADD = 5'b00010, OP_XOR = 5'b00011;
  localparam logic [4:0] OP_SLL = 5'b00100, OP_SRL = 5'b00101, OP_SUB = 5'b00110, OP_SRA = 5'b00111;
  localparam logic [4:0] OP_SLT = 5'b01000, OP_SLTU = 5'b01001;
  typedef enum logic {IDLE, MDU} state_t;
  state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [4:0] base, dec_op, op_n;
  logic dec_ill, dec_m, ill_n, valid_n, start_n, kill_n, accept;
  logic f7z, f7s, f7m, shift;
  assign f7z = in_funct7 == 7'b0000000;
  assign f7s = in_funct7 == 7'b0100000;
  assign f7m = in_funct7 == 7'b0000001;
  assign shift = in_funct3[1:0] == 2'b01;
  always_comb begin
    case (in_funct3)
      3'b000: base = OP_ADD;
      3'b001: base = OP_SLL;
      3'b010: base = OP_SLT;
      3'b011: base = OP_SLTU;
      3'b100: base = OP_XOR;
      3'b101: base = OP_SRL;
      3'b110: base = OP_OR;
      default: base = OP_AND;
    endcase
  end
  always_comb begin
    dec_op = OP_ADD;
    dec_ill = 1'b0;
    dec_m = 1'b0;
    case (in_alu_op)
      2'b01: begin
        dec_ill = in_funct3[2:1] == 2'b01;
        dec_op = ~in_funct3[2] ? OP_SUB : in_funct3[1] ? OP_SLTU : OP_SLT;
      end
      2'b11: begin
        dec_op = (shift & f7s & in_funct3[2]) ? OP_SRA : base;
        dec_ill = shift & ~f7z & ~(f7s & in_funct3[2]);
      end
      2'b10: begin
        dec_m = f7m & (M_EXT != 0);
        dec_op = dec_m ? {2'b10, in_funct3} :
                 (f7s & in_funct3 == 3'b101) ? OP_SRA :
                 (f7s & in_funct3 == 3'b000) ? OP_SUB : base;
        dec_ill = ~(f7z | dec_m | (f7s & (in_funct3 == 3'b000 | in_funct3 == 3'b101)));
      end
      default: ;
    endcase
    if (dec_ill) dec_op = OP_ADD;
  end
  assign in_ready = (state == IDLE) & (~out_valid | ex_ready);
  assign accept = in_valid & in_ready & ~flush;
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    valid_n = out_valid;
    op_n = out_alu_op;
    ill_n = out_illegal;
    start_n = 1'b0;
    kill_n = 1'b0;
    if (flush) begin
      state_n = IDLE;
      cnt_n = '0;
      valid_n = 1'b0;
      kill_n = (state == MDU) | out_mdu_start;
    end else if (state == MDU) begin
      valid_n = cnt == '0;
      state_n = cnt == '0 ? IDLE : MDU;
      cnt_n = cnt == '0 ? cnt : cnt - 1'b1;
    end else if (accept) begin
      op_n = dec_op;
      ill_n = dec_ill;
      valid_n = ~dec_m;
      start_n = dec_m;
      state_n = dec_m ? MDU : IDLE;
      cnt_n = dec_m ? (in_funct3[2] ? DIV_L : MUL_L) : cnt;
    end else if (ex_ready) begin
      valid_n = 1'b0;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      out_valid <= 1'b0;
      out_alu_op <= OP_ADD;
      out_illegal <= 1'b0;
      out_mdu_start <= 1'b0;
      out_mdu_kill <= 1'b0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      out_valid <= valid_n;
      out_alu_op <= op_n;
      out_illegal <= ill_n;
      out_mdu_start <= start_n;
      out_mdu_kill <= kill_n;
    end
  end
endmodule

// File: tb/tb_alu_control_seq.sv
// tb_alu_control_seq: directed plus random checks of alu_control_seq against a transaction-level model
module tb_alu_control_seq;
  localparam int MUL_LAT = 2;
  localparam int DIV_LAT = 32;
  logic clk = 1'b0, rst = 1'b1, in_valid = 1'b0, flush = 1'b0, ex_ready = 1'b0;
  logic [1:0] in_alu_op = '0;
  logic [2:0] in_funct3 = '0;
  logic [6:0] in_funct7 = '0;
  logic in_ready, out_valid, out_illegal, out_mdu_start, out_mdu_kill;
  logic [4:0] out_alu_op;
  logic b_in_ready, b_out_valid, b_out_illegal, b_out_mdu_start, b_out_mdu_kill;
  logic [4:0] b_out_alu_op;
  int total = 0, bad = 0, cyc = 0, n;
  bit m_valid, m_ill, m_start, m_kill, m_busy;
  logic [4:0] m_op;
  int m_done;
  logic [4:0] base_tab [8] = '{5'b00010, 5'b00100, 5'b01000, 5'b01001, 5'b00011, 5'b00101, 5'b00001, 5'b00000};
  logic [2:0] b2b_f3 [4] = '{3'b111, 3'b110, 3'b100, 3'b011};
  logic [4:0] b2b_op [4] = '{5'b00000, 5'b00001, 5'b00011, 5'b01001};
  alu_control_seq #(.M_EXT(1), .MUL_CYCLES(MUL_LAT), .DIV_CYCLES(DIV_LAT)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_alu_op(in_alu_op),
    .in_funct3(in_funct3), .in_funct7(in_funct7), .flush(flush), .ex_ready(ex_ready),
    .out_valid(out_valid), .out_alu_op(out_alu_op), .out_illegal(out_illegal),
    .out_mdu_start(out_mdu_start), .out_mdu_kill(out_mdu_kill));
  alu_control_seq #(.M_EXT(0), .MUL_CYCLES(MUL_LAT), .DIV_CYCLES(DIV_LAT)) dut_nom (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(b_in_ready), .in_alu_op(in_alu_op),
    .in_funct3(in_funct3), .in_funct7(in_funct7), .flush(flush), .ex_ready(ex_ready),
    .out_valid(b_out_valid), .out_alu_op(b_out_alu_op), .out_illegal(b_out_illegal),
    .out_mdu_start(b_out_mdu_start), .out_mdu_kill(b_out_mdu_kill));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask
  task automatic ref_dec(input logic [1:0] a, input logic [2:0] f3, input logic [6:0] f7,
                         output logic [4:0] op, output logic il, output logic m);
    op = 5'b00010;
    il = 1'b0;
    m = 1'b0;
    if (a == 2'd1) begin
      il = (f3 == 3'd2 || f3 == 3'd3);
      op = il ? 5'b00010 : f3 < 3'd2 ? 5'b00110 : f3 < 3'd6 ? 5'b01000 : 5'b01001;
    end else if (a == 2'd3) begin
      if (!(f3 == 3'd1 || f3 == 3'd5) || f7 == 7'd0) op = base_tab[f3];
      else if (f3 == 3'd5 && f7 == 7'h20) op = 5'b00111;
      else il = 1'b1;
    end else if (a == 2'd2) begin
      if (f7 == 7'd0) op = base_tab[f3];
      else if (f7 == 7'h20 && f3 == 3'd0) op = 5'b00110;
      else if (f7 == 7'h20 && f3 == 3'd5) op = 5'b00111;
      else if (f7 == 7'h01) begin
        op = 5'd16 + 5'(f3);
        m = 1'b1;
      end else il = 1'b1;
    end
  endtask
  task automatic step(input bit v, input logic [1:0] a, input logic [2:0] f3, input logic [6:0] f7,
                      input bit fl, input bit exr, input bit r);
    logic [4:0] op;
    logic il, m;
    bit rdy;
    chk("out_valid", out_valid, m_valid);
    chk("out_alu_op", out_alu_op, m_op);
    chk("out_illegal", out_illegal, m_ill);
    chk("out_mdu_start", out_mdu_start, m_start);
    chk("out_mdu_kill", out_mdu_kill, m_kill);
    in_valid = v;
    in_alu_op = a;
    in_funct3 = f3;
    in_funct7 = f7;
    flush = fl;
    ex_ready = exr;
    rst = r;
    #1;
    rdy = !m_busy && (!m_valid || exr);
    chk("in_ready", in_ready, rdy);
    if (r) begin
      {m_valid, m_ill, m_start, m_kill, m_busy} = '0;
      m_op = 5'b00010;
    end else if (fl) begin
      m_kill = m_busy || m_start;
      {m_valid, m_start, m_busy} = '0;
    end else begin
      m_kill = 1'b0;
      m_start = 1'b0;
      if (m_busy) begin
        if (cyc + 1 == m_done) {m_valid, m_busy} = 2'b10;
      end else if (v && rdy) begin
        ref_dec(a, f3, f7, op, il, m);
        m_op = op;
        m_ill = il;
        m_valid = !m;
        m_start = m;
        m_busy = m;
        m_done = cyc + 1 + (f3[2] ? DIV_LAT : MUL_LAT);
      end else if (exr) m_valid = 1'b0;
    end
    cyc++;
    @(posedge clk);
    @(negedge clk);
  endtask
  task automatic idle(input bit exr);
    step(1'b0, 2'b00, 3'b000, 7'h00, 1'b0, exr, 1'b0);
  endtask
  initial begin
    {m_valid, m_ill, m_start, m_kill, m_busy} = '0;
    m_op = 5'b00010;
    m_done = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    step(1'b0, 2'b00, 3'b000, 7'h00, 1'b0, 1'b0, 1'b1);
    chk("rst_valid", out_valid, 1'b0);
    chk("rst_op", out_alu_op, 5'b00010);
    idle(1'b1);
    chk("rst_ready", in_ready, 1'b1);
    step(1'b1, 2'b10, 3'b101, 7'h20, 1'b0, 1'b1, 1'b0);
    chk("sra", out_alu_op, 5'b00111);
    chk("sra_valid", out_valid, 1'b1);
    step(1'b1, 2'b10, 3'b010, 7'h20, 1'b0, 1'b1, 1'b0);
    chk("r_illegal", out_illegal, 1'b1);
    chk("r_illegal_op", out_alu_op, 5'b00010);
    step(1'b1, 2'b01, 3'b110, 7'h00, 1'b0, 1'b1, 1'b0);
    chk("bltu", out_alu_op, 5'b01001);
    step(1'b1, 2'b11, 3'b000, 7'h20, 1'b0, 1'b1, 1'b0);
    chk("addi", out_alu_op, 5'b00010);
    chk("addi_legal", out_illegal, 1'b0);
    step(1'b1, 2'b11, 3'b001, 7'h01, 1'b0, 1'b1, 1'b0);
    chk("slli_illegal", out_illegal, 1'b1);
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 2'b10, b2b_f3[i], 7'h00, 1'b0, 1'b1, 1'b0);
      chk("b2b_op", out_alu_op, b2b_op[i]);
      chk("b2b_valid", out_valid, 1'b1);
    end
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 2'b10, 3'b000, 7'h00, 1'b0, 1'b0, 1'b0);
      chk("hold_op", out_alu_op, 5'b01001);
      chk("hold_ready", in_ready, 1'b0);
    end
    idle(1'b1);
    step(1'b1, 2'b10, 3'b100, 7'h01, 1'b0, 1'b1, 1'b0);
    chk("div_start", out_mdu_start, 1'b1);
    chk("div_ready", in_ready, 1'b0);
    chk("nom_illegal", b_out_illegal, 1'b1);
    chk("nom_valid", b_out_valid, 1'b1);
    chk("nom_start", b_out_mdu_start, 1'b0);
    n = 1;
    while (!out_valid && n < 40) begin
      idle(1'b1);
      n++;
    end
    chk("div_latency", n, DIV_LAT + 1);
    chk("div_op", out_alu_op, 5'b10100);
    step(1'b1, 2'b10, 3'b101, 7'h01, 1'b0, 1'b1, 1'b0);
    repeat (9) idle(1'b1);
    step(1'b0, 2'b00, 3'b000, 7'h00, 1'b1, 1'b1, 1'b0);
    chk("flush_kill", out_mdu_kill, 1'b1);
    chk("flush_valid", out_valid, 1'b0);
    chk("flush_ready", in_ready, 1'b1);
    step(1'b1, 2'b10, 3'b000, 7'h00, 1'b1, 1'b1, 1'b0);
    chk("flush_accept", out_valid, 1'b0);
    idle(1'b1);
    step(1'b1, 2'b10, 3'b110, 7'h01, 1'b0, 1'b1, 1'b0);
    idle(1'b1);
    step(1'b0, 2'b00, 3'b000, 7'h00, 1'b0, 1'b1, 1'b1);
    chk("rst_mdu_kill", out_mdu_kill, 1'b0);
    chk("rst_mdu_valid", out_valid, 1'b0);
    chk("rst_mdu_op", out_alu_op, 5'b00010);
    step(1'b1, 2'b11, 3'b100, 7'h00, 1'b0, 1'b0, 1'b0);
    idle(1'b0);
    chk("hold_valid", out_valid, 1'b1);
    step(1'b0, 2'b00, 3'b000, 7'h00, 1'b0, 1'b0, 1'b1);
    chk("rst_hold_valid", out_valid, 1'b0);
    chk("rst_hold_op", out_alu_op, 5'b00010);
    repeat (3000) begin
      logic [6:0] f7;
      case ($urandom_range(0, 3))
        0: f7 = 7'h00;
        1: f7 = 7'h20;
        2: f7 = 7'h01;
        default: f7 = 7'($urandom);
      endcase
      step($urandom_range(0, 3) != 0, 2'($urandom), 3'($urandom), f7,
           $urandom_range(0, 15) == 0, $urandom_range(0, 3) != 0, $urandom_range(0, 199) == 0);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/alu_control_seq.md
# alu_control_seq

Registered, handshaked successor to the single-cycle ALU control decoder for the rv32i core. It decodes the full RV32I ALU operation set, plus RV32M when enabled, from ALUOp, funct3 and funct7 into a 5-bit ALU operation code. It sits between decode and execute as one valid/ready pipeline register. For M-extension ops it starts the multiply/divide unit, counts that unit's fixed latency, and stalls decode until the result slot is ready.

## Interface
Parameters:
- M_EXT, 1, when 1 decode RV32M (funct7=0000001); when 0 those encodings are illegal
- MUL_CYCLES, 2, MDU latency for funct3[2]=0 M ops; must be ≥1
- DIV_CYCLES, 32, MDU latency for funct3[2]=1 M ops; must be ≥1

Ports (one clock; reset is synchronous and active-high):
- clk  input  1  clock, rising edge
- rst  input  1  synchronous active-high reset
- in_valid  input  1  decode presents an instruction
- in_ready  output  1  block accepts this cycle (combinational)
- in_alu_op  input  2  00 load/store/jal/auipc, 01 branch, 10 R-type, 11 I-type ALU
- in_funct3  input  3  instruction[14:12]
- in_funct7  input  7  instruction[31:25]
- flush  input  1  kill held/in-flight op (branch taken, trap)
- ex_ready  input  1  execute consumes out_* this cycle
- out_valid  output  1  out_alu_op/out_illegal valid
- out_alu_op  output  5  operation code
- out_illegal  output  1  encoding was illegal
- out_mdu_start  output  1  one-cycle pulse to start the MDU
- out_mdu_kill  output  1  one-cycle pulse to abort the MDU

## Operation
- Op codes:
  - AND 00000, OR 00001, ADD 00010, XOR 00011, SLL 00100, SRL 00101, SUB 00110, SRA 00111, SLT 01000, SLTU 01001.
  - M ops are {2'b10, funct3}: MUL 10000 … REMU 10111.
- Decode by in_alu_op:
  - 00: ADD, funct fields ignored.
  - 01 (branch): funct3 000/001 gives SUB; 100/101 gives SLT; 110/111 gives SLTU; 010/011 is illegal.
  - 11 (I-type): funct7 is ignored except for shifts. 001 requires funct7=0000000. 101 with funct7=0000000 gives SRL, with 0100000 gives SRA. Any other funct7 on a shift is illegal.
  - 10 (R-type):
    - funct7=0000000 selects the base op by funct3.
    - funct7=0100000 is legal only for funct3 000 (SUB) and 101 (SRA).
    - funct7=0000001 selects an M op when M_EXT=1, and is illegal when M_EXT=0.
    - Any other funct7 is illegal.
- Illegal encodings: out_alu_op=ADD and out_illegal=1. Handled as a single-cycle op.
- Accept condition: in_valid & in_ready & !flush.
- in_ready = (state==IDLE) & (!out_valid | ex_ready).
- States:
  - IDLE:
    - Accept of a non-M op: out_* registered, out_valid=1 next cycle.
    - Accept of an M op: go to MDU. out_alu_op is registered, out_valid=0, out_mdu_start=1 for one cycle, cnt=LAT-1. LAT is MUL_CYCLES or DIV_CYCLES according to funct3[2].
  - MDU:
    - in_ready=0.
    - cnt decrements each cycle.
    - When cnt==0: out_valid=1 next cycle and state returns to IDLE.
- Hold: if out_valid & !ex_ready, all out_* are stable.
- Clear: out_valid & ex_ready with no accept gives out_valid=0 next cycle. If an accept happens in the same cycle, the new op replaces the old one (back-to-back throughput of 1/cycle for non-M ops).
- cnt width is clog2(max(MUL_CYCLES,DIV_CYCLES)+1).

## Timing
- Reset values:
  - out_valid=0, out_alu_op=00010, out_illegal=0, out_mdu_start=0, out_mdu_kill=0.
  - state=IDLE, cnt=0, in_ready=1 once rst is low.
- Latency from accept at cycle t:
  - Non-M op: out_valid at t+1.
  - M op: out_mdu_start at t+1, out_valid at t+LAT+1.
- flush (synchronous, priority over accept and over ex_ready):
  - Next cycle out_valid=0, state=IDLE, cnt=0, out_mdu_start=0.
  - If state was MDU, or out_mdu_start was high in the flush cycle: out_mdu_kill=1 for one cycle.
  - in_ready is unaffected in the flush cycle, but nothing is captured.
- rst during MDU: returns to reset values; out_mdu_kill is not pulsed.
- out_alu_op is stable from t+1 through consumption for M ops. The MDU may sample it with out_mdu_start.

## Test plan
- Reset then R-type sweep: in_alu_op=10, funct7=0100000, funct3=101 → out_alu_op=00111 at t+1; funct3=010 with the same funct7 → out_illegal=1, out_alu_op=00010.
- Branch/I-type decode: alu_op=01, funct3=110 → 01001; alu_op=11, funct3=000, funct7=0100000 → 00010 (ADDI, not SUB); alu_op=11, funct3=001, funct7=0000001 → illegal.
- Back-to-back with ex_ready=1: 4 non-M ops on consecutive cycles → out_valid high 4 consecutive cycles, ops in order; ex_ready=0 for 3 cycles → in_ready=0 and out_* held.
- M op, DIV_CYCLES=32: funct7=0000001, funct3=100 → out_mdu_start at t+1, in_ready=0 for 32 cycles, out_valid with 10100 at t+33; M_EXT=0 → out_illegal=1 at t+1, no start pulse.
- Flush mid-MDU at t+10 → out_mdu_kill=1 at t+11, out_valid stays 0, in_ready=1 at t+11; flush on the same cycle as an accept → nothing captured.
- Synchronous rst asserted during MDU and while holding a result → all outputs at reset values the next cycle, no kill pulse.
